iis_capture_ctrl: RTL and testbench
===================================

// Module: iis_capture_ctrl
// PURPOSE
//  Sequences the I2S receive datapath into whole stereo frames. It pairs left/right sample
//  strobes from the I2S read logic, applies the channel mode, and queues frames in a small
//  FIFO toward a valid/ready consumer (DMA or AXI-stream bridge). Overflow and L/R pairing
//  loss are counted or flagged, never silently hidden.
// PARAMETERS
//  DATA_W      24  sample width, two's complement
//  FIFO_DEPTH  4   frame FIFO depth; power of 2, >=2
//  CNT_W       8   overflow counter width, saturating
// PORTS
//  clk_100m  in   1         system clock, 100 MHz
//  rst_n     in   1         asynchronous, active-low reset
//  enable    in   1         capture enable (level)
//  mode      in   2         00 stereo, 01 left only, 10 right only, 11 mono (L+R)/2
//  l_data    in   DATA_W    left sample from I2S reader
//  l_valid   in   1         1-cycle strobe: l_data is new
//  r_data    in   DATA_W    right sample from I2S reader
//  r_valid   in   1         1-cycle strobe: r_data is new
//  m_data    out  2*DATA_W  frame {left,right}; FIFO head
//  m_valid   out  1         FIFO not empty
//  m_ready   in   1         consumer accepts head when m_valid&&m_ready
//  ovf_clr   in   1         synchronous clear of ovf_cnt
//  ovf_cnt   out  CNT_W     frames dropped on full FIFO, saturating
//  sync_err  out  1         sticky: left arrived while waiting for right; cleared by ovf_clr
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, m_valid=0, m_data=0, ovf_cnt=0, sync_err=0, mode_r=00.
//  FSM states IDLE, WAIT_L, WAIT_R, PUSH:
//   IDLE:   enable=1 -> WAIT_L; mode_r<=mode. Mode is latched only here.
//   WAIT_L: stereo/mono: l_valid -> latch L, go to WAIT_R. Left-only: l_valid -> latch L,
//           R=0, go to PUSH. Right-only: r_valid -> latch R, L=0, go to PUSH. Other strobes ignored.
//           In stereo/mono, an r_valid here is an orphan; drop it silently.
//   WAIT_R: r_valid -> latch R, go to PUSH. l_valid (right missed) -> replace L, set
//           sync_err, stay. Both strobes in the same cycle: take R, go to PUSH, L ignored.
//   PUSH:   one cycle. Write the frame if FIFO not full, else ovf_cnt++ (saturate at
//           2^CNT_W-1). Next state WAIT_L.
//   enable=0 in any state -> IDLE on next edge. Partial frame is discarded. A frame in PUSH
//   that edge is still written. FIFO contents are kept and keep draining.
//  Mono: s = sext(L)+sext(R) in DATA_W+1 bits, arithmetic >>1 (rounds toward -inf).
//   m_data = {s[DATA_W-1:0], s[DATA_W-1:0]}.
//  Latency: final strobe sampled at edge k -> PUSH after k -> written at edge k+1 ->
//   m_valid=1 after edge k+1 if FIFO was empty.
//  FIFO: show-ahead. Pop on m_valid&&m_ready. Full is evaluated before the same-cycle pop,
//   so a push into a full FIFO is dropped even if a pop occurs that cycle.
//   Push and pop when not full/empty: occupancy unchanged. Pointers wrap mod FIFO_DEPTH.
//  m_data holds its value while m_valid=0 and changes only on pop or on a write into empty.
//  ovf_clr takes priority over a same-cycle increment. Result: ovf_cnt=0, sync_err=0.
// TESTING
//  T1 stereo: L=0x123456 then R=0xABCDEF, m_ready=1 -> m_data=0x123456ABCDEF, m_valid for
//     1 cycle, 2 cycles after r_valid.
//  T2 mono: L=0x000003, R=0x000004 -> both halves 0x000003. L=0xFFFFFF, R=0x000000 ->
//     0xFFFFFF (-1>>1 = -1).
//  T3 overflow: m_ready=0, push 6 stereo frames, depth 4 -> 4 queued, ovf_cnt=2. Drain
//     gives frames 1..4 in order. ovf_clr -> ovf_cnt=0.
//  T4 pairing: r_valid first (orphan dropped), then L1, L2, R1 -> one frame {L2,R1},
//     sync_err=1.
//  T5 modes: right-only, R=0x00AAAA -> m_data=0x00000000AAAA. Left-only ignores r_valid.
//  T6 disable/reset: enable=0 in WAIT_R -> no frame, queued frames still drain.
//     rst_n low mid-drain -> m_valid=0, ovf_cnt=0 immediately (async).

Source files
------------

// File: rtl/iis_capture_ctrl.sv
// iis_capture_ctrl: pairs I2S left/right strobes into stereo frames and queues them toward a valid/ready consumer
module iis_capture_ctrl #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   l_data,
  input  logic                l_valid,
  input  logic [DATA_W-1:0]   r_data,
  input  logic                r_valid,
  output logic [2*DATA_W-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  input  logic                ovf_clr,
  output logic [CNT_W-1:0]    ovf_cnt,
  output logic                sync_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_L, WAIT_R, PUSH} state_t;
  state_t              r_state, w_next;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_l, r_r;
  logic [2*DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wp, r_rp;
  logic [CNT_W-1:0]    r_ovf;
  logic                r_sync;
  logic                w_pair, w_lat_l, w_lat_r, w_zero_l, w_zero_r, w_sync;
  logic                w_full, w_empty, w_push, w_pop, w_drop;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_avg;
  logic [2*DATA_W-1:0] w_frame;
  // stereo and mono both need a left-then-right pair; single-channel modes complete on one strobe
  assign w_pair  = r_mode[0] == r_mode[1];
  // a full FIFO rejects the push even when the head is popped in the same cycle
  assign w_full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_empty = r_wp == r_rp;
  assign w_push  = r_state == PUSH && !w_full;
  assign w_drop  = r_state == PUSH && w_full;
  assign w_pop   = !w_empty && m_ready;
  // sign-extended sum then arithmetic halve, so mono rounds toward minus infinity
  assign w_sum   = {r_l[DATA_W-1], r_l} + {r_r[DATA_W-1], r_r};
  assign w_avg   = w_sum[DATA_W:1];
  assign w_frame = &r_mode ? {w_avg, w_avg} : {r_l, r_r};
  assign m_data  = r_mem[r_rp[AW-1:0]];
  assign m_valid = !w_empty;
  assign ovf_cnt = r_ovf;
  assign sync_err = r_sync;
  // next-state and sample-latch decode; dropping enable abandons any partial frame
  always_comb begin
    w_next   = r_state;
    w_lat_l  = 1'b0;
    w_lat_r  = 1'b0;
    w_zero_l = 1'b0;
    w_zero_r = 1'b0;
    w_sync   = 1'b0;
    case (r_state)
      IDLE:   w_next = enable ? WAIT_L : IDLE;
      WAIT_L: begin
        if (w_pair && l_valid) begin
          w_lat_l = 1'b1;
          w_next  = WAIT_R;
        end else if (r_mode == 2'b01 && l_valid) begin
          w_lat_l  = 1'b1;
          w_zero_r = 1'b1;
          w_next   = PUSH;
        end else if (r_mode == 2'b10 && r_valid) begin
          w_lat_r  = 1'b1;
          w_zero_l = 1'b1;
          w_next   = PUSH;
        end
      end
      WAIT_R: begin
        if (r_valid) begin
          w_lat_r = 1'b1;
          w_next  = PUSH;
        end else if (l_valid) begin
          w_lat_l = 1'b1;
          w_sync  = 1'b1;
        end
      end
      default: w_next = WAIT_L;
    endcase
    if (!enable) begin
      w_next   = IDLE;
      w_lat_l  = 1'b0;
      w_lat_r  = 1'b0;
      w_zero_l = 1'b0;
      w_zero_r = 1'b0;
      w_sync   = 1'b0;
    end
  end
  // state register
  always_ff @(posedge clk_100m or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // channel mode is sampled only when leaving IDLE; sample holding registers
  always_ff @(posedge clk_100m or negedge rst_n)
    if (!rst_n) begin
      r_mode <= 2'b00;
      r_l    <= '0;
      r_r    <= '0;
    end else begin
      if (r_state == IDLE && enable) r_mode <= mode;
      r_l <= w_lat_l ? l_data : w_zero_l ? '0 : r_l;
      r_r <= w_lat_r ? r_data : w_zero_r ? '0 : r_r;
    end
  // show-ahead frame FIFO; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk_100m or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= w_frame;
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  // saturating drop counter and sticky pairing error; clear wins over a same-cycle event
  always_ff @(posedge clk_100m or negedge rst_n)
    if (!rst_n) begin
      r_ovf  <= '0;
      r_sync <= 1'b0;
    end else if (ovf_clr) begin
      r_ovf  <= '0;
      r_sync <= 1'b0;
    end else begin
      if (w_drop && ~&r_ovf) r_ovf <= r_ovf + CNT_W'(1);
      if (w_sync) r_sync <= 1'b1;
    end
endmodule

// File: tb/tb_iis_capture_ctrl.sv
// tb_iis_capture_ctrl: scoreboard bench for the I2S frame capture controller
module tb_iis_capture_ctrl;
  localparam int DW = 24;
  localparam int CW = 8;
  logic          clk_100m = 0;
  logic          rst_n = 0;
  logic          enable = 0;
  logic [1:0]    mode = 0;
  logic [DW-1:0] l_data = 0;
  logic          l_valid = 0;
  logic [DW-1:0] r_data = 0;
  logic          r_valid = 0;
  logic [2*DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 0;
  logic          ovf_clr = 0;
  logic [CW-1:0] ovf_cnt;
  logic          sync_err;
  int n_chk = 0;
  int n_fail = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] mon_e;

  iis_capture_ctrl #(.DATA_W(DW), .FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .enable(enable), .mode(mode),
    .l_data(l_data), .l_valid(l_valid), .r_data(r_data), .r_valid(r_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt), .sync_err(sync_err)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk_100m)
    if (rst_n && m_valid && m_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL frame: got unexpected %h expected none", m_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_data !== mon_e) begin
          n_fail++;
          $display("FAIL frame: got %h expected %h", m_data, mon_e);
        end
      end
    end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100m);
      #1;
    end
  endtask

  task automatic pl(input logic [DW-1:0] d);
    l_data = d;
    l_valid = 1;
    cyc(1);
    l_valid = 0;
  endtask

  task automatic pr(input logic [DW-1:0] d);
    r_data = d;
    r_valid = 1;
    cyc(1);
    r_valid = 0;
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pl(l);
    pr(r);
    cyc(1);
  endtask

  task automatic start(input logic [1:0] m);
    enable = 0;
    cyc(1);
    mode = m;
    enable = 1;
    cyc(1);
  endtask

  task automatic clr();
    ovf_clr = 1;
    cyc(1);
    ovf_clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #22;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_sync_err", sync_err, 0);
    @(posedge clk_100m);
    #1;
    rst_n = 1;
    cyc(1);

    start(2'b00);
    m_ready = 1;
    pl(24'h123456);
    pr(24'hABCDEF);
    exp_q.push_back(48'h123456ABCDEF);
    check("t1_lat_push", m_valid, 0);
    cyc(1);
    check("t1_lat_valid", m_valid, 1);
    check("t1_data", m_data, 48'h123456ABCDEF);
    cyc(1);
    check("t1_one_cycle", m_valid, 0);

    start(2'b11);
    frame(24'h000003, 24'h000004);
    exp_q.push_back(48'h000003000003);
    frame(24'hFFFFFF, 24'h000000);
    exp_q.push_back(48'hFFFFFFFFFFFF);
    frame(24'hFFFFFD, 24'h000000);
    exp_q.push_back(48'hFFFFFEFFFFFE);
    frame(24'h7FFFFF, 24'h7FFFFF);
    exp_q.push_back(48'h7FFFFF7FFFFF);
    cyc(2);

    start(2'b00);
    m_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      frame(24'h100000 + DW'(i), 24'h200000 + DW'(i));
      if (i <= 4) exp_q.push_back({24'h100000 + DW'(i), 24'h200000 + DW'(i)});
    end
    check("t3_ovf", ovf_cnt, 2);
    check("t3_head", m_data, 48'h100001200001);
    pl(24'h100007);
    pr(24'h200007);
    ovf_clr = 1;
    cyc(1);
    ovf_clr = 0;
    check("t3_clr_prio", ovf_cnt, 0);
    m_ready = 1;
    cyc(6);
    check("t3_drained", m_valid, 0);

    start(2'b00);
    pr(24'h0BAD00);
    check("t4_orphan_ok", sync_err, 0);
    pl(24'h111111);
    pl(24'h222222);
    check("t4_sync_set", sync_err, 1);
    pr(24'h333333);
    exp_q.push_back(48'h222222333333);
    cyc(1);
    clr();
    check("t4_sync_clr", sync_err, 0);
    pl(24'h444444);
    l_data = 24'h555555;
    r_data = 24'h666666;
    l_valid = 1;
    r_valid = 1;
    cyc(1);
    l_valid = 0;
    r_valid = 0;
    exp_q.push_back(48'h444444666666);
    cyc(1);
    check("t4_both_nosync", sync_err, 0);

    start(2'b10);
    pl(24'h777777);
    pr(24'h00AAAA);
    exp_q.push_back(48'h00000000AAAA);
    cyc(1);
    start(2'b01);
    pr(24'h123123);
    pl(24'h555555);
    exp_q.push_back(48'h555555000000);
    cyc(3);

    start(2'b00);
    m_ready = 0;
    frame(24'hA00001, 24'hB00001);
    exp_q.push_back(48'hA00001B00001);
    frame(24'hA00002, 24'hB00002);
    exp_q.push_back(48'hA00002B00002);
    pl(24'hA00003);
    enable = 0;
    cyc(1);
    pr(24'hB00003);
    m_ready = 1;
    cyc(4);
    check("t6_drain_disabled", m_valid, 0);
    start(2'b00);
    pl(24'hC00001);
    pr(24'hD00001);
    exp_q.push_back(48'hC00001D00001);
    enable = 0;
    cyc(3);
    check("t6_push_on_disable", m_valid, 0);
    check("queue_empty", exp_q.size(), 0);

    start(2'b00);
    m_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      frame(24'hE00000 + DW'(i), 24'hF00000 + DW'(i));
      if (i <= 4) exp_q.push_back({24'hE00000 + DW'(i), 24'hF00000 + DW'(i)});
    end
    check("t6_ovf", ovf_cnt, 1);
    m_ready = 1;
    cyc(1);
    rst_n = 0;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_ovf", ovf_cnt, 0);
    check("t6_rst_data", m_data, 0);
    exp_q.delete();
    m_ready = 0;
    cyc(1);
    rst_n = 1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
